peak_meter: RTL and testbench
=============================

# peak_meter

Level-metering stage that sits directly downstream of the phase-invert stage and consumes its 16-bit signed audio output, one sample per `clk_48` cycle. It tracks the absolute peak with a hold-then-linear-decay ballistic, flags clipping with a stretched indicator, and drives an 8-segment thermometer bar for the channel-strip front panel. It is a pure observer and does not modify the audio path.

## Interface
Parameters:
- `HOLD_SAMPLES`, default 24000: number of samples a new peak is held before decay starts (0.5 s at 48 kHz); legal range ≥1.
- `DECAY_STEP`, default 4: amount subtracted from the held peak per sample during decay; legal range ≥1.
- `CLIP_THRESH`, default 32767: magnitude at or above which a sample counts as clipped.
- `CLIP_HOLD`, default 48000: number of cycles `clip` stays high after the last clipped sample; legal range ≥1.

Ports:
- `clk_48`, in, 1: sample-rate clock; one audio sample per rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `audioIn`, in, 16 signed: audio sample, normally the phase stage's `phaseOut`.
- `peakClear`, in, 1: synchronous clear of the peak and clip state.
- `peakLevel`, out, 15 unsigned: current held or decaying peak magnitude.
- `clip`, out, 1: stretched clip indicator.
- `meterBar`, out, 8: thermometer bar; bit k is lit when `peakLevel` ≥ k·4096+1.

## Operation
- Stage 1 registers `mag` = saturating |`audioIn`|. An input of −32768 maps to 32767, so `mag` is always 15 bits.
- Stage 2 is an FSM with states IDLE, HOLD and DECAY, plus a hold counter and a clip counter. On each edge, in priority order:
  - `peakClear`: set `peakLevel`=0, `clip`=0, both counters=0, and go to IDLE. Clear wins over every simultaneous event.
  - `mag` ≥ `peakLevel` and `mag` ≠ 0: set `peakLevel`=`mag`, hold counter=`HOLD_SAMPLES`−1, and go to HOLD. This applies from any state, and an equal-magnitude sample restarts the hold.
  - HOLD: if the hold counter is 0, go to DECAY; otherwise decrement it. `peakLevel` does not change.
  - DECAY: set `peakLevel` = `peakLevel` − `DECAY_STEP`, saturating at 0. Go to IDLE on the cycle the result becomes 0.
  - IDLE: `peakLevel` stays 0.
- Clip path, evaluated in parallel with the FSM:
  - If `mag` ≥ `CLIP_THRESH`: `clip`=1 and clip counter=`CLIP_HOLD`−1.
  - Otherwise, if the counter is nonzero, decrement it.
  - Otherwise set `clip`=0.
  - Result: `clip` stays high for exactly `CLIP_HOLD` cycles after the last clipped sample's stage-2 edge.
- `meterBar` is registered and is computed from the next-state `peakLevel`, so it changes on the same edge as `peakLevel`.

## Timing
- Reset values: `peakLevel`=0, `meterBar`=0, `clip`=0, stage-1 `mag`=0, FSM=IDLE, both counters=0.
- Latency: a sample present at edge k is registered as `mag` at edge k, and `peakLevel`, `meterBar` and `clip` reflect it after edge k+1 (2-edge latency).
- No handshake: every cycle carries a valid sample.
- `peakClear` takes effect at the edge where it is sampled high. The stage-1 register is not cleared, so a loud sample already in `mag` may re-seed the peak on the following edge.
- Reset asserted mid-hold or mid-decay forces all outputs to their reset values immediately, asynchronously.
- Decay saturates at 0 and never wraps. The hold counter never underflows.
- Arithmetic:
  - Counter widths are `$clog2` of the parameter value, with a minimum width of 1.
  - The decay subtraction is done at 16 bits, then saturated.

## Structure
- Shared package `meter_pkg` contains:
  - `SAMPLE_W`=16 and `MAG_W`=15;
  - the state enum (IDLE, HOLD, DECAY);
  - the function `sat_abs(logic signed [15:0])`;
  - the function `bar_encode(peak)` for the 8 thresholds.
- Optional sub-module `peak_ballistics` holds the FSM, hold counter and decay. The top level keeps the stage-1 abs register, the clip stretcher and the bar register.

## Test plan
The bench overrides parameters to `HOLD_SAMPLES`=4, `DECAY_STEP`=1000, `CLIP_HOLD`=3.

- **Reset:** assert `reset` mid-stream with `peakLevel`=20000 → all outputs 0 immediately; IDLE after release.
- **Hold and decay:** one sample of 10000 followed by zeros → `peakLevel`=10000 two edges later, held 4 cycles, then 9000, 8000, … 0, then IDLE; `meterBar` steps 8'b00000111 → 8'b00000011 → … → 0.
- **Saturation and clip stretch:** `audioIn`=−32768 → `peakLevel`=32767, `meterBar`=8'hFF, `clip`=1 for exactly 3 cycles after that sample's stage-2 edge, then 0.
- **Retrigger:** 10000 then, during hold, 8000 → no change. 10000 again during decay → hold restarts at 10000. A value of 500 during decay while `peakLevel`=2000 → ignored.
- **Clear priority:** `peakClear` on the same edge as a new peak 30000 → `peakLevel`=0, `clip`=0, IDLE.
- **Full-scale sine:** 48-sample ±32767 sine → `peakLevel` tracks up to 32767. `clip` pulses at each crest and stays continuously high when the crest spacing is less than `CLIP_HOLD`.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared types and helpers for the peak meter: widths, ballistics state
// encoding, saturating magnitude and thermometer-bar encoding.
package meter_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned MAG_W    = 15;
  localparam int unsigned BAR_W    = 8;
  localparam int unsigned BAR_STEP = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } meter_state_e;

  // -32768 has no positive twin in 16 bits; it clamps to full scale.
  function automatic logic [MAG_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] u;
    u = s;
    if (u[SAMPLE_W-1]) begin
      u = (~u) + SAMPLE_W'(1);
    end
    if (u[SAMPLE_W-1]) begin
      return '1;
    end
    return u[MAG_W-1:0];
  endfunction

  function automatic logic [BAR_W-1:0] bar_encode(input logic [MAG_W-1:0] peak);
    logic [BAR_W-1:0] b;
    b = '0;
    for (int unsigned k = 0; k < BAR_W; k++) begin
      b[k] = ({1'b0, peak} >= SAMPLE_W'(k * BAR_STEP + 1));
    end
    return b;
  endfunction

endpackage

// File: rtl/peak_ballistics.sv
// Hold-then-linear-decay peak follower. Exposes both the registered peak
// and its next-state value so the caller can register derived outputs in step.
module peak_ballistics
  import meter_pkg::*;
#(
  parameter int unsigned HOLD_SAMPLES = 24000,
  parameter int unsigned DECAY_STEP   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [MAG_W-1:0] mag_i,
  output logic [MAG_W-1:0] peak_o,
  output logic [MAG_W-1:0] peak_d_o
);

  localparam int unsigned         HOLD_W    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [SAMPLE_W-1:0] STEP      = SAMPLE_W'(DECAY_STEP);

  meter_state_e        state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [MAG_W-1:0]    peak_q, peak_d;
  logic [SAMPLE_W-1:0] peak_ext;
  logic [MAG_W-1:0]    decayed;

  // Subtraction is carried at 16 bits; anything at or below the step floors to 0.
  always_comb begin
    peak_ext = {1'b0, peak_q};
    if (peak_ext > STEP) begin
      decayed = MAG_W'(peak_ext - STEP);
    end else begin
      decayed = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    peak_d  = peak_q;
    if (clear_i) begin
      state_d = IDLE;
      hold_d  = '0;
      peak_d  = '0;
    end else if ((mag_i >= peak_q) && (mag_i != '0)) begin
      state_d = HOLD;
      hold_d  = HOLD_LOAD;
      peak_d  = mag_i;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_q == '0) begin
            state_d = DECAY;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        DECAY: begin
          peak_d = decayed;
          if (decayed == '0) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          peak_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      peak_q  <= peak_d;
    end
  end

  assign peak_o   = peak_q;
  assign peak_d_o = peak_d;

endmodule

// File: rtl/peak_meter.sv
// Level meter observing the post-phase audio: registered magnitude, peak
// ballistics, stretched clip indicator and an 8-segment thermometer bar.
module peak_meter
  import meter_pkg::*;
#(
  parameter int unsigned HOLD_SAMPLES = 24000,
  parameter int unsigned DECAY_STEP   = 4,
  parameter int unsigned CLIP_THRESH  = 32767,
  parameter int unsigned CLIP_HOLD    = 48000
) (
  input  logic                       clk_48,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] audioIn,
  input  logic                       peakClear,
  output logic [MAG_W-1:0]           peakLevel,
  output logic                       clip,
  output logic [BAR_W-1:0]           meterBar
);

  localparam int unsigned         CLIP_W    = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD) : 1;
  localparam logic [CLIP_W-1:0]   CLIP_LOAD = CLIP_W'(CLIP_HOLD - 1);
  // A threshold above full scale can never be reached; clamp so it fits 16 bits.
  localparam int unsigned         CLIP_LIM  = (CLIP_THRESH > 32768) ? 32768 : CLIP_THRESH;
  localparam logic [SAMPLE_W-1:0] CLIP_T    = SAMPLE_W'(CLIP_LIM);

  logic [MAG_W-1:0]  mag_q;
  logic [MAG_W-1:0]  peak_d;
  logic              clip_q, clip_d;
  logic [CLIP_W-1:0] clipcnt_q, clipcnt_d;
  logic [BAR_W-1:0]  bar_q, bar_d;

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      mag_q <= '0;
    end else begin
      mag_q <= sat_abs(audioIn);
    end
  end

  peak_ballistics #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_STEP   (DECAY_STEP)
  ) u_ballistics (
    .clk_i    (clk_48),
    .rst_i    (reset),
    .clear_i  (peakClear),
    .mag_i    (mag_q),
    .peak_o   (peakLevel),
    .peak_d_o (peak_d)
  );

  always_comb begin
    clip_d    = clip_q;
    clipcnt_d = clipcnt_q;
    if (peakClear) begin
      clip_d    = 1'b0;
      clipcnt_d = '0;
    end else if ({1'b0, mag_q} >= CLIP_T) begin
      clip_d    = 1'b1;
      clipcnt_d = CLIP_LOAD;
    end else if (clipcnt_q != '0) begin
      clipcnt_d = clipcnt_q - CLIP_W'(1);
    end else begin
      clip_d = 1'b0;
    end
  end

  // Encoding the next-state peak keeps the bar aligned with peakLevel.
  always_comb begin
    bar_d = bar_encode(peak_d);
  end

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      clip_q    <= 1'b0;
      clipcnt_q <= '0;
      bar_q     <= '0;
    end else begin
      clip_q    <= clip_d;
      clipcnt_q <= clipcnt_d;
      bar_q     <= bar_d;
    end
  end

  assign clip     = clip_q;
  assign meterBar = bar_q;

endmodule

// File: tb/tb_peak_meter.sv
// Scoreboard bench for peak_meter: the driver queues hand-computed outputs,
// the monitor pops and compares one entry per output observation.
module tb_peak_meter;

  logic               clk_48;
  logic               reset;
  logic signed [15:0] audioIn;
  logic               peakClear;
  logic [14:0]        peakLevel;
  logic               clip;
  logic [7:0]         meterBar;

  typedef struct {
    logic [14:0] peak;
    logic [7:0]  bar;
    logic        clip;
    bit          chk_peak;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  event mon_ev;

  peak_meter #(
    .HOLD_SAMPLES (4),
    .DECAY_STEP   (1000),
    .CLIP_THRESH  (32767),
    .CLIP_HOLD    (3)
  ) dut (
    .clk_48    (clk_48),
    .reset     (reset),
    .audioIn   (audioIn),
    .peakClear (peakClear),
    .peakLevel (peakLevel),
    .clip      (clip),
    .meterBar  (meterBar)
  );

  initial begin
    clk_48 = 1'b0;
    forever #5 clk_48 = ~clk_48;
  end

  initial begin
    forever begin
      @(posedge clk_48);
      #1;
      -> mon_ev;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (clip !== e.clip) begin
          errors++;
          $display("FAIL %s clip got %0b expected %0b", e.tag, clip, e.clip);
        end
        if (e.chk_peak) begin
          checks++;
          if (peakLevel !== e.peak) begin
            errors++;
            $display("FAIL %s peakLevel got %0d expected %0d", e.tag, peakLevel, e.peak);
          end
          checks++;
          if (meterBar !== e.bar) begin
            errors++;
            $display("FAIL %s meterBar got %b expected %b", e.tag, meterBar, e.bar);
          end
        end
      end
    end
  end

  // Expectation is the output after the edge that samples these inputs.
  task automatic step(input int a, input logic clr, input int p, input int b,
                      input logic c, input bit chk, input string tag);
    exp_t e;
    @(negedge clk_48);
    audioIn   = 16'(a);
    peakClear = clr;
    e.peak     = 15'(p);
    e.bar      = 8'(b);
    e.clip     = c;
    e.chk_peak = chk;
    e.tag      = tag;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    e.peak     = '0;
    e.bar      = '0;
    e.clip     = 1'b0;
    e.chk_peak = 1'b1;
    e.tag      = tag;
    sb_q.push_back(e);
    -> mon_ev;
  endtask

  initial begin
    int sv;
    logic c;
    reset     = 1'b1;
    audioIn   = '0;
    peakClear = 1'b0;
    #3 check_now("reset_state");
    @(negedge clk_48);
    reset = 1'b0;

    // Hold and decay
    step(10000, 0, 0,     'h00, 0, 1, "hd_load");
    step(0,     0, 10000, 'h07, 0, 1, "hd_peak");
    step(0,     0, 10000, 'h07, 0, 1, "hd_hold2");
    step(0,     0, 10000, 'h07, 0, 1, "hd_hold1");
    step(0,     0, 10000, 'h07, 0, 1, "hd_hold0");
    step(0,     0, 10000, 'h07, 0, 1, "hd_todecay");
    step(0,     0, 9000,  'h07, 0, 1, "hd_9000");
    step(0,     0, 8000,  'h03, 0, 1, "hd_8000");
    step(0,     0, 7000,  'h03, 0, 1, "hd_7000");
    step(0,     0, 6000,  'h03, 0, 1, "hd_6000");
    step(0,     0, 5000,  'h03, 0, 1, "hd_5000");
    step(0,     0, 4000,  'h01, 0, 1, "hd_4000");
    step(0,     0, 3000,  'h01, 0, 1, "hd_3000");
    step(0,     0, 2000,  'h01, 0, 1, "hd_2000");
    step(0,     0, 1000,  'h01, 0, 1, "hd_1000");
    step(0,     0, 0,     'h00, 0, 1, "hd_zero");
    step(0,     0, 0,     'h00, 0, 1, "hd_idle");

    // Saturation and clip stretch
    step(-32768, 0, 0,     'h00, 0, 1, "sat_load");
    step(0,      0, 32767, 'hFF, 1, 1, "sat_peak");
    step(0,      0, 32767, 'hFF, 1, 1, "sat_clip2");
    step(0,      0, 32767, 'hFF, 1, 1, "sat_clip3");
    step(0,      0, 32767, 'hFF, 0, 1, "sat_clipoff");
    step(0,      0, 32767, 'hFF, 0, 1, "sat_todecay");
    step(0,      0, 31767, 'hFF, 0, 1, "sat_decay");
    step(0,      1, 0,     'h00, 0, 1, "sat_clear");

    // Retrigger
    step(10000, 0, 0,     'h00, 0, 1, "rt_load");
    step(8000,  0, 10000, 'h07, 0, 1, "rt_peak");
    step(0,     0, 10000, 'h07, 0, 1, "rt_lower_ignored");
    step(0,     0, 10000, 'h07, 0, 1, "rt_hold1");
    step(0,     0, 10000, 'h07, 0, 1, "rt_hold0");
    step(0,     0, 10000, 'h07, 0, 1, "rt_todecay");
    step(0,     0, 9000,  'h07, 0, 1, "rt_9000");
    step(10000, 0, 8000,  'h03, 0, 1, "rt_8000");
    step(0,     0, 10000, 'h07, 0, 1, "rt_reload");
    step(0,     0, 10000, 'h07, 0, 1, "rt_rh2");
    step(0,     0, 10000, 'h07, 0, 1, "rt_rh1");
    step(0,     0, 10000, 'h07, 0, 1, "rt_rh0");
    step(0,     0, 10000, 'h07, 0, 1, "rt_rdecay");
    step(0,     0, 9000,  'h07, 0, 1, "rt_r9000");
    step(0,     0, 8000,  'h03, 0, 1, "rt_r8000");
    step(0,     0, 7000,  'h03, 0, 1, "rt_r7000");
    step(0,     0, 6000,  'h03, 0, 1, "rt_r6000");
    step(0,     0, 5000,  'h03, 0, 1, "rt_r5000");
    step(0,     0, 4000,  'h01, 0, 1, "rt_r4000");
    step(0,     0, 3000,  'h01, 0, 1, "rt_r3000");
    step(500,   0, 2000,  'h01, 0, 1, "rt_r2000");
    step(0,     0, 1000,  'h01, 0, 1, "rt_small_ignored");
    step(0,     0, 0,     'h00, 0, 1, "rt_zero");
    step(0,     0, 0,     'h00, 0, 1, "rt_idle");

    // Clear priority and stage-1 re-seed
    step(30000, 0, 0,     'h00, 0, 1, "clr_pre");
    step(0,     1, 0,     'h00, 0, 1, "clr_vs_peak");
    step(0,     0, 0,     'h00, 0, 1, "clr_idle");
    step(32767, 0, 0,     'h00, 0, 1, "clr_pre_clip");
    step(0,     1, 0,     'h00, 0, 1, "clr_vs_clip");
    step(0,     0, 0,     'h00, 0, 1, "clr_noclip");
    step(0,     0, 0,     'h00, 0, 1, "clr_quiet");
    step(20000, 1, 0,     'h00, 0, 1, "clr_with_sample");
    step(0,     0, 20000, 'h1F, 0, 1, "clr_reseed");
    step(0,     0, 20000, 'h1F, 0, 1, "clr_reseed_hold");

    // Asynchronous reset mid-hold
    @(negedge clk_48);
    audioIn   = '0;
    peakClear = 1'b0;
    #3 reset = 1'b1;
    #1 check_now("reset_midhold");
    @(negedge clk_48);
    reset = 1'b0;
    step(0,    0, 0,    'h00, 0, 1, "post_rst_idle");
    step(4500, 0, 0,    'h00, 0, 1, "post_rst_load");
    step(0,    0, 4500, 'h03, 0, 1, "post_rst_peak");
    step(0,    0, 4500, 'h03, 0, 1, "post_rst_h2");
    step(0,    0, 4500, 'h03, 0, 1, "post_rst_h1");
    step(0,    0, 4500, 'h03, 0, 1, "post_rst_h0");
    step(0,    0, 4500, 'h03, 0, 1, "post_rst_todecay");
    step(0,    0, 3500, 'h01, 0, 1, "sat_dec_3500");
    step(0,    0, 2500, 'h01, 0, 1, "sat_dec_2500");
    step(0,    0, 1500, 'h01, 0, 1, "sat_dec_1500");
    step(0,    0, 500,  'h01, 0, 1, "sat_dec_500");
    step(0,    0, 0,    'h00, 0, 1, "sat_dec_floor");
    step(0,    0, 0,    'h00, 0, 1, "sat_dec_idle");

    // Full-scale sine: crests at n=12 and n=36
    for (int n = 0; n < 48; n++) begin
      sv = int'(32767.0 * $sin(2.0 * 3.14159265358979 * n / 48.0));
      c  = ((n >= 13) && (n <= 15)) || ((n >= 37) && (n <= 39));
      if (n == 0) begin
        step(sv, 0, 0, 'h00, c, 1, $sformatf("sine_%0d", n));
      end else if (((n >= 13) && (n <= 17)) || ((n >= 37) && (n <= 41))) begin
        step(sv, 0, 32767, 'hFF, c, 1, $sformatf("sine_%0d", n));
      end else if ((n == 18) || (n == 42)) begin
        step(sv, 0, 31767, 'hFF, c, 1, $sformatf("sine_%0d", n));
      end else begin
        step(sv, 0, 0, 'h00, c, 0, $sformatf("sine_%0d", n));
      end
    end

    // Clipped samples two apart keep clip continuously high
    step(32767, 0, 0,     'h00, 0, 0, "cont_0");
    step(0,     0, 32767, 'hFF, 1, 1, "cont_1");
    step(32767, 0, 32767, 'hFF, 1, 1, "cont_2");
    step(0,     0, 32767, 'hFF, 1, 1, "cont_3");
    step(32767, 0, 32767, 'hFF, 1, 1, "cont_4");
    step(0,     0, 32767, 'hFF, 1, 1, "cont_5");
    step(0,     0, 32767, 'hFF, 1, 1, "cont_6");
    step(0,     0, 32767, 'hFF, 1, 1, "cont_7");
    step(0,     0, 32767, 'hFF, 0, 1, "cont_8");
    step(0,     0, 32767, 'hFF, 0, 1, "cont_9");
    step(0,     0, 31767, 'hFF, 0, 1, "cont_10");
    step(0,     1, 0,     'h00, 0, 1, "final_clear");

    repeat (3) @(negedge clk_48);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
